// File: rtl/up_counter_arb_pkg.sv
// up_counter_arb_pkg: shared state encoding, defaults and one-hot helper for the counter arbiter.
package up_counter_arb_pkg;
  localparam int N_REQ_DEF = 2;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic logic [7:0] onehot(input int idx);
    return 8'(1) << idx;
  endfunction
endpackage

// File: rtl/up_counter_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr and wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             any_req,
  output logic [PW-1:0]    winner
);
  localparam logic [PW:0] N = (PW+1)'(N_REQ);
  logic [N_REQ-1:0] rot;
  logic [PW-1:0] idx;
  function automatic logic [PW-1:0] wrap(input logic [PW:0] s);
    return PW'(s >= N ? s - N : s);
  endfunction
  always_comb begin
    rot = '0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) rot[i] = req[wrap({1'b0, ptr} + (PW+1)'(i))];
    for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) idx = PW'(i);
  end
  assign any_req = |req;
  assign winner = wrap({1'b0, ptr} + {1'b0, idx});
endmodule

// File: rtl/up_counter_arbiter.sv
// up_counter_arbiter: round-robin sharing of one interval counter among N_REQ requesters.
module up_counter_arbiter
  import up_counter_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       count
);
  localparam int PW = $clog2(N_REQ);
  state_t state, state_d;
  logic [N_REQ-1:0] gnt_d, done_d;
  logic busy_d, any_req;
  logic [WIDTH-1:0] count_d, cur_len, cur_len_d;
  logic [PW-1:0] owner, owner_d, ptr, ptr_d, winner, nxt;
  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (.req(req), .ptr(ptr), .any_req(any_req), .winner(winner));
  assign nxt = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  // Abort is tested before terminal count so a dropped request never sees done.
  always_comb begin
    state_d = state;
    gnt_d = gnt;
    done_d = '0;
    busy_d = busy;
    count_d = count;
    cur_len_d = cur_len;
    owner_d = owner;
    ptr_d = ptr;
    case (state)
      ST_IDLE: begin
        count_d = '0;
        if (any_req) begin
          state_d = ST_RUN;
          gnt_d = N_REQ'(onehot(int'(winner)));
          owner_d = winner;
          cur_len_d = len[int'(winner)*WIDTH +: WIDTH];
          busy_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!req[owner]) begin
          state_d = ST_IDLE;
          gnt_d = '0;
          busy_d = 1'b0;
          count_d = '0;
          ptr_d = nxt;
        end else if (count == cur_len) begin
          state_d = ST_DONE;
          gnt_d = '0;
          done_d = N_REQ'(onehot(int'(owner)));
          ptr_d = nxt;
        end else count_d = count + 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d = 1'b0;
        count_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      gnt <= '0;
      done <= '0;
      busy <= 1'b0;
      count <= '0;
      cur_len <= '0;
      owner <= '0;
      ptr <= '0;
    end else begin
      state <= state_d;
      gnt <= gnt_d;
      done <= done_d;
      busy <= busy_d;
      count <= count_d;
      cur_len <= cur_len_d;
      owner <= owner_d;
      ptr <= ptr_d;
    end
  end
endmodule

// File: tb/tb_up_counter_arbiter.sv
// tb_up_counter_arbiter: directed checks of grant, count, done and busy timing with N_REQ=2, WIDTH=4.
module tb_up_counter_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req = '0;
  logic [7:0] len = '0;
  logic [1:0] gnt, done;
  logic busy;
  logic [3:0] count;
  logic [8:0] obs;
  int checks = 0;
  int failures = 0;
  up_counter_arbiter #(.N_REQ(2), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );
  always #5 clk = ~clk;
  // Observed word laid out as {gnt, done, busy, count}.
  assign obs = {gnt, done, busy, count};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL reset gnt/done/busy/count got=%b want=%b", obs, 9'b00_00_0_0000);
    end
  endtask
  task automatic test_single();
    req = 2'b01;
    len = 8'h03;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) len = 8'h07;
      checks++;
      if (obs !== {2'b01, 2'b00, 1'b1, 4'(k)}) begin
        failures++;
        $display("FAIL single_run k=%0d got=%b want=%b", k, obs, {2'b01, 2'b00, 1'b1, 4'(k)});
      end
    end
    step();
    checks++;
    if (obs !== 9'b00_01_1_0011) begin
      failures++;
      $display("FAIL single_done got=%b want=%b", obs, 9'b00_01_1_0011);
    end
    req = '0;
    step();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL single_idle got=%b want=%b", obs, 9'b00_00_0_0000);
    end
  endtask
  task automatic test_contention();
    do_reset();
    req = 2'b11;
    len = 8'h12;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs !== {2'b01, 2'b00, 1'b1, 4'(k)}) begin
        failures++;
        $display("FAIL cont_run0 k=%0d got=%b want=%b", k, obs, {2'b01, 2'b00, 1'b1, 4'(k)});
      end
    end
    step();
    checks++;
    if (obs !== 9'b00_01_1_0010) begin
      failures++;
      $display("FAIL cont_done0 got=%b want=%b", obs, 9'b00_01_1_0010);
    end
    step();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL cont_gap got=%b want=%b", obs, 9'b00_00_0_0000);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (obs !== {2'b10, 2'b00, 1'b1, 4'(k)}) begin
        failures++;
        $display("FAIL cont_run1 k=%0d got=%b want=%b", k, obs, {2'b10, 2'b00, 1'b1, 4'(k)});
      end
    end
    step();
    checks++;
    if (obs !== 9'b00_10_1_0001) begin
      failures++;
      $display("FAIL cont_done1 got=%b want=%b", obs, 9'b00_10_1_0001);
    end
    req = '0;
    step();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL cont_idle got=%b want=%b", obs, 9'b00_00_0_0000);
    end
  endtask
  task automatic test_zero_len();
    req = 2'b10;
    len = 8'h00;
    step();
    checks++;
    if (obs !== 9'b10_00_1_0000) begin
      failures++;
      $display("FAIL zero_run got=%b want=%b", obs, 9'b10_00_1_0000);
    end
    step();
    checks++;
    if (obs !== 9'b00_10_1_0000) begin
      failures++;
      $display("FAIL zero_done got=%b want=%b", obs, 9'b00_10_1_0000);
    end
    req = '0;
    step();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL zero_idle got=%b want=%b", obs, 9'b00_00_0_0000);
    end
  endtask
  task automatic test_max_len();
    req = 2'b01;
    len = 8'h0F;
    for (int k = 0; k < 16; k++) begin
      step();
      checks++;
      if (obs !== {2'b01, 2'b00, 1'b1, 4'(k)}) begin
        failures++;
        $display("FAIL max_run k=%0d got=%b want=%b", k, obs, {2'b01, 2'b00, 1'b1, 4'(k)});
      end
    end
    step();
    checks++;
    if (obs !== 9'b00_01_1_1111) begin
      failures++;
      $display("FAIL max_done got=%b want=%b", obs, 9'b00_01_1_1111);
    end
    req = '0;
    step();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL max_idle got=%b want=%b", obs, 9'b00_00_0_0000);
    end
  endtask
  task automatic test_abort();
    do_reset();
    req = 2'b01;
    len = 8'h09;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (obs !== {2'b01, 2'b00, 1'b1, 4'(k)}) begin
        failures++;
        $display("FAIL abort_run k=%0d got=%b want=%b", k, obs, {2'b01, 2'b00, 1'b1, 4'(k)});
      end
    end
    req = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (obs !== 9'b00_00_0_0000) begin
        failures++;
        $display("FAIL abort_idle k=%0d got=%b want=%b", k, obs, 9'b00_00_0_0000);
      end
    end
    req = 2'b11;
    step();
    checks++;
    if (obs !== 9'b10_00_1_0000) begin
      failures++;
      $display("FAIL abort_ptr got=%b want=%b", obs, 9'b10_00_1_0000);
    end
    req = '0;
    step();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL abort_drop1 got=%b want=%b", obs, 9'b00_00_0_0000);
    end
  endtask
  task automatic test_reset_mid_run();
    req = 2'b01;
    len = 8'h09;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (obs !== {2'b01, 2'b00, 1'b1, 4'(k)}) begin
        failures++;
        $display("FAIL rstmid_run k=%0d got=%b want=%b", k, obs, {2'b01, 2'b00, 1'b1, 4'(k)});
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL rstmid_clear got=%b want=%b", obs, 9'b00_00_0_0000);
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (obs !== {2'b01, 2'b00, 1'b1, 4'(k)}) begin
        failures++;
        $display("FAIL rstmid_regrant k=%0d got=%b want=%b", k, obs, {2'b01, 2'b00, 1'b1, 4'(k)});
      end
    end
    req = '0;
    step();
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      failures++;
      $display("FAIL rstmid_idle got=%b want=%b", obs, 9'b00_00_0_0000);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_max_len();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
